// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL wrapper, the lock sequencer and the logic it resets.
// The sequencer uses the master modport. Its consumers use the slave modport.
interface pll_lock_sequencer_if #(
   parameter int CNT_WIDTH = 8
);
   logic                 locked_in;
   logic                 reset_out;
   logic                 ready;
   logic                 pll_rst;
   logic [CNT_WIDTH-1:0] lock_loss_count;

   modport master (
      input  locked_in,
      output reset_out,
      output ready,
      output pll_rst,
      output lock_loss_count
   );

   modport slave (
      output locked_in,
      input  reset_out,
      input  ready,
      input  pll_rst,
      input  lock_loss_count
   );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Turns the raw PLL LOCK signal into a debounced design-wide reset and a ready flag.
// If lock never arrives, it pulses a PLL reset request.
module pll_lock_sequencer #(
   parameter int SYNC_STAGES       = 2,
   parameter int STABLE_CYCLES     = 1024,
   parameter int RESET_HOLD_CYCLES = 16,
   parameter int TIMEOUT_CYCLES    = 65536,
   parameter int PLL_RST_CYCLES    = 4,
   parameter int CNT_WIDTH         = 8
) (
   input  logic                  clock_in,
   input  logic                  reset,
   pll_lock_sequencer_if.master  bus
);

   // One timer is shared by all states, so it is sized for the longest limit.
   localparam int MAX_AB = (STABLE_CYCLES > RESET_HOLD_CYCLES) ? STABLE_CYCLES : RESET_HOLD_CYCLES;
   localparam int MAX_CD = (TIMEOUT_CYCLES > PLL_RST_CYCLES) ? TIMEOUT_CYCLES : PLL_RST_CYCLES;
   localparam int T_MAX  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int TW     = (T_MAX > 1) ? $clog2(T_MAX) : 1;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABLE    = 2'd1,
      RUN       = 2'd2,
      PLL_RESET = 2'd3
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   locked_s;
   logic [TW-1:0]          timer;
   logic                   reset_out_q;
   logic                   ready_q;
   logic                   pll_rst_q;
   logic [CNT_WIDTH-1:0]   loss_cnt;

   assign locked_s = sync_q[SYNC_STAGES-1];

   // NOTE: every register here is updated with <=, so each one reads the value from before the edge.
   //       The synchronizer shift and the FSM therefore see consistent state.
   always_ff @(posedge clock_in) begin
      if (reset) begin
         state       <= WAIT_LOCK;
         sync_q      <= '0;
         timer       <= '0;
         reset_out_q <= 1'b1;
         ready_q     <= 1'b0;
         pll_rst_q   <= 1'b0;
         loss_cnt    <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.locked_in};

         case (state)
            WAIT_LOCK: begin
               if (locked_s) begin
                  state <= STABLE;
                  timer <= '0;
               end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                  state     <= PLL_RESET;
                  pll_rst_q <= 1'b1;
                  timer     <= '0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            // A drop here is treated as a glitch and is not counted as a lock loss.
            STABLE: begin
               if (!locked_s) begin
                  state <= WAIT_LOCK;
                  timer <= '0;
               end else if (timer == TW'(STABLE_CYCLES - 1)) begin
                  state       <= RUN;
                  reset_out_q <= 1'b0;
                  timer       <= '0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            RUN: begin
               if (!locked_s) begin
                  state       <= WAIT_LOCK;
                  reset_out_q <= 1'b1;
                  ready_q     <= 1'b0;
                  timer       <= '0;
                  if (loss_cnt != '1) loss_cnt <= loss_cnt + 1'b1;
               end else if (timer == TW'(RESET_HOLD_CYCLES - 1)) begin
                  ready_q <= 1'b1;
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            // Lock is deliberately ignored while the PLL is being reset.
            PLL_RESET: begin
               if (timer == TW'(PLL_RST_CYCLES - 1)) begin
                  state     <= WAIT_LOCK;
                  pll_rst_q <= 1'b0;
                  timer     <= '0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            default: begin
               state <= WAIT_LOCK;
               timer <= '0;
            end
         endcase
      end
   end

   assign bus.reset_out       = reset_out_q;
   assign bus.ready           = ready_q;
   assign bus.pll_rst         = pll_rst_q;
   assign bus.lock_loss_count = loss_cnt;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small timing parameters.
// The vector table covers the lock, glitch and timeout timelines; short sequences cover lock loss and reset.
module tb_pll_lock_sequencer;

   localparam int SYNC_STAGES       = 2;
   localparam int STABLE_CYCLES     = 8;
   localparam int RESET_HOLD_CYCLES = 4;
   localparam int TIMEOUT_CYCLES    = 32;
   localparam int PLL_RST_CYCLES    = 4;
   localparam int CNT_WIDTH         = 2;

   logic clock_in = 1'b0;
   logic reset    = 1'b1;

   pll_lock_sequencer_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();

   pll_lock_sequencer #(
      .SYNC_STAGES      (SYNC_STAGES),
      .STABLE_CYCLES    (STABLE_CYCLES),
      .RESET_HOLD_CYCLES(RESET_HOLD_CYCLES),
      .TIMEOUT_CYCLES   (TIMEOUT_CYCLES),
      .PLL_RST_CYCLES   (PLL_RST_CYCLES),
      .CNT_WIDTH        (CNT_WIDTH)
   ) dut (
      .clock_in(clock_in),
      .reset   (reset),
      .bus     (bus)
   );

   always #5 clock_in = ~clock_in;

   // at_edge counts posedges since reset was released. Edge 1 is the first edge with reset low.
   // lock is the value driven on locked_in for the edges up to and including at_edge.
   typedef struct {
      logic           rst_first;
      int             at_edge;
      logic           lock;
      logic           ro;
      logic           rdy;
      logic           prst;
      logic [1:0]     cnt;
   } vec_t;

   vec_t vecs[20];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   edge_no  = 0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (edge %0d): got %0h, expected %0h", name, edge_no, act, exp);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the edge for sampling and driving.
   task automatic step(input int n);
      repeat (n) @(posedge clock_in);
      #1;
      edge_no += n;
   endtask

   task automatic check_all(input string tag, input logic ro, input logic rdy,
                            input logic prst, input logic [1:0] cnt);
      check({tag, ".reset_out"}, {7'd0, bus.reset_out}, {7'd0, ro});
      check({tag, ".ready"},     {7'd0, bus.ready},     {7'd0, rdy});
      check({tag, ".pll_rst"},   {7'd0, bus.pll_rst},   {7'd0, prst});
      check({tag, ".count"},     {6'd0, bus.lock_loss_count}, {6'd0, cnt});
   endtask

   // Hold reset for a few edges and release it, driving locked_in for edge 1 at the same time.
   task automatic do_reset(input logic lock);
      reset         = 1'b1;
      bus.locked_in = 1'b0;
      step(3);
      reset         = 1'b0;
      bus.locked_in = lock;
      edge_no       = 0;
   endtask

   initial begin
      // Clean lock: reset_out falls at 2+8+1 = 11, ready rises 4 edges later.
      vecs[0]  = '{1'b1, 10, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
      vecs[1]  = '{1'b0, 11, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
      vecs[2]  = '{1'b0, 14, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
      vecs[3]  = '{1'b0, 15, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
      vecs[4]  = '{1'b0, 20, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
      // One-cycle glitch at edge 6: lock returns at edge 7, so reset_out falls at 7+10 = 17.
      vecs[5]  = '{1'b1, 5,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
      vecs[6]  = '{1'b0, 6,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
      vecs[7]  = '{1'b0, 16, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
      vecs[8]  = '{1'b0, 17, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
      vecs[9]  = '{1'b0, 21, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
      // No lock: pll_rst is high on edges 32..35 and rises again at 68.
      // Lock arrives during the second pulse but only takes effect after edge 72, so reset_out falls at 81.
      vecs[10] = '{1'b1, 31, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
      vecs[11] = '{1'b0, 32, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0};
      vecs[12] = '{1'b0, 35, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0};
      vecs[13] = '{1'b0, 36, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
      vecs[14] = '{1'b0, 67, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
      vecs[15] = '{1'b0, 68, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0};
      vecs[16] = '{1'b0, 71, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0};
      vecs[17] = '{1'b0, 72, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
      vecs[18] = '{1'b0, 80, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
      vecs[19] = '{1'b0, 81, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};

      bus.locked_in = 1'b0;
      step(2);
      check_all("reset_state", 1'b1, 1'b0, 1'b0, 2'd0);

      for (int i = 0; i < 20; i++) begin
         if (vecs[i].rst_first) do_reset(vecs[i].lock);
         bus.locked_in = vecs[i].lock;
         if (vecs[i].at_edge > edge_no) step(vecs[i].at_edge - edge_no);
         check_all($sformatf("vec%0d", i), vecs[i].ro, vecs[i].rdy, vecs[i].prst, vecs[i].cnt);
      end

      // Lock loss from RUN: the drop is seen on edge 3, then the relock takes 11 edges.
      do_reset(1'b1);
      step(20);
      check_all("loss.pre", 1'b0, 1'b1, 1'b0, 2'd0);
      bus.locked_in = 1'b0;
      step(2);
      check_all("loss.e2", 1'b0, 1'b1, 1'b0, 2'd0);
      step(1);
      check_all("loss.e3", 1'b1, 1'b0, 1'b0, 2'd1);
      bus.locked_in = 1'b1;
      step(10);
      check_all("relock.e10", 1'b1, 1'b0, 1'b0, 2'd1);
      step(1);
      check_all("relock.e11", 1'b0, 1'b0, 1'b0, 2'd1);

      // Five lock losses: the count must saturate at 3 and never wrap.
      do_reset(1'b1);
      for (int i = 1; i <= 5; i++) begin
         bus.locked_in = 1'b1;
         step(12);
         check($sformatf("sat%0d.run", i), {7'd0, bus.reset_out}, 8'd0);
         bus.locked_in = 1'b0;
         step(3);
         check($sformatf("sat%0d.count", i), {6'd0, bus.lock_loss_count},
               (i < 3) ? 8'(i) : 8'd3);
      end

      // A one-cycle reset in RUN clears everything on the next edge and restarts from WAIT_LOCK.
      bus.locked_in = 1'b1;
      step(16);
      check_all("rst_run.pre", 1'b0, 1'b1, 1'b0, 2'd3);
      reset = 1'b1;
      step(1);
      reset   = 1'b0;
      edge_no = 0;
      check_all("rst_run.post", 1'b1, 1'b0, 1'b0, 2'd0);
      step(10);
      check_all("rst_run.e10", 1'b1, 1'b0, 1'b0, 2'd0);
      step(1);
      check_all("rst_run.e11", 1'b0, 1'b0, 1'b0, 2'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
